fixed_point_accumulator: RTL and testbench



---
 rtl/fixed_point_accumulator_pkg.sv | 14 +
 rtl/accum_add_core.sv | 15 +
 rtl/fixed_point_accumulator.sv | 107 ++++++++++
 tb/tb_fixed_point_accumulator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_accumulator_pkg.sv
// Shared types and default sizes for the streaming fixed-point accumulator.
package fixed_point_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_N     = 32;
   localparam int DEF_G     = 8;
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/accum_add_core.sv
// Combinational W-bit ripple adder used in the accumulator feedback path.
module accum_add_core #(
   parameter int W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] c,
   output logic         co
);

   // Widen by one bit so the carry-out falls out of the same add.
   assign {co, c} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/fixed_point_accumulator.sv
// Sums a block of len signed N-bit samples into a guard-extended W-bit
// register and hands the total out on a valid/ready port.
module fixed_point_accumulator
   import fixed_point_accumulator_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int G     = DEF_G,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   len,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N+G-1:0]     out_sum,
   output logic               out_ovf,
   output logic [CNT_W-1:0]   out_count
);

   localparam int W = N + G;

   state_t             state_q, state_d;
   logic [W-1:0]       acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               ovf_q, ovf_d;

   logic [W-1:0]       sext;
   logic [W-1:0]       sum;
   logic               add_co;   // carry-out: overflow is judged from sign bits instead

   // Sign-extend the sample to accumulator width (works for G == 0 too).
   assign sext = W'($signed(in_data));

   accum_add_core #(.W(W)) u_add (
      .a  (acc_q),
      .b  (sext),
      .ci (1'b0),
      .c  (sum),
      .co (add_co)
   );

   // State and datapath registers; reset discards any partial block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, accumulate-on-handshake and handshake outputs.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               len_d   = len;
               state_d = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = sum;
               cnt_d = cnt_q + CNT_W'(1);
               // Same-sign operands producing a different-sign result.
               ovf_d = ovf_q | ((acc_q[W-1] == sext[W-1]) && (sum[W-1] != acc_q[W-1]));
               if (cnt_q == len_q - CNT_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed bench: a default-sized DUT checked every cycle against a block
// model, plus an N=8/G=0 DUT for the signed-overflow case.
module tb_fixed_point_accumulator;

   typedef struct {
      logic [63:0] sum;
      bit          ovf;
      int          cnt;
   } exp_t;

   logic clk, rst;

   // default DUT (N=32, G=8)
   logic        start, in_valid, out_ready;
   logic [15:0] len;
   logic [31:0] in_data;
   logic        busy, in_ready, out_valid, out_ovf;
   logic [39:0] out_sum;
   logic [15:0] out_count;

   // narrow DUT (N=8, G=0)
   logic        start_b, in_valid_b, out_ready_b;
   logic [15:0] len_b;
   logic [7:0]  in_data_b;
   logic        busy_b, in_ready_b, out_valid_b, out_ovf_b;
   logic [7:0]  out_sum_b;
   logic [15:0] out_count_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   fixed_point_accumulator u_dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_ovf(out_ovf), .out_count(out_count)
   );

   fixed_point_accumulator #(.N(8), .G(0), .CNT_W(16)) u_dut8 (
      .clk(clk), .rst(rst), .start(start_b), .len(len_b), .busy(busy_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sum(out_sum_b),
      .out_ovf(out_ovf_b), .out_count(out_count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Block model: true integer sums, wrapped to w bits after each sample;
   // overflow whenever an unwrapped partial sum leaves the signed range.
   function automatic void model(input longint s[$], input int w,
                                 output logic [63:0] sum, output bit ovf);
      longint acc, t, lo, hi, m;
      m   = (longint'(1) << w);
      lo  = -(m / 2);
      hi  = (m / 2) - 1;
      acc = 0;
      ovf = 0;
      foreach (s[i]) begin
         t = acc + s[i];
         if (t < lo || t > hi) ovf = 1;
         acc = t % m;
         if (acc > hi) acc -= m;
         if (acc < lo) acc += m;
      end
      sum = 64'(acc) & 64'(m - 1);
   endfunction

   // Per-cycle compare for the default DUT.
   bit   have_exp = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (rst) begin
         have_exp = 0;
      end else begin
         chk("busy_consistent", busy, in_ready | out_valid);
         chk("ready_valid_excl", in_ready & out_valid, 1'b0);
         if (out_valid) begin
            if (!have_exp) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out_valid", 1, 0);
                  cur.sum = 'x; cur.ovf = 0; cur.cnt = 0;
               end else begin
                  cur = exp_q.pop_front();
               end
               have_exp = 1;
            end
            chk("model_sum",   64'(out_sum),   cur.sum);
            chk("model_ovf",   64'(out_ovf),   64'(cur.ovf));
            chk("model_count", 64'(out_count), 64'(cur.cnt));
            if (out_ready) have_exp = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a block, feed samples with gap[i] idle cycles before sample i,
   // return one cycle after the final sample handshake.
   task automatic run_block(input bit b, input int l, input longint s[$], input int gap[$]);
      logic [63:0] ms;
      bit          mo;
      exp_t        e;
      if (b) begin start_b = 1; len_b = 16'(l); end
      else begin
         start = 1; len = 16'(l);
         model(s, 40, ms, mo);
         e.sum = ms; e.ovf = mo; e.cnt = l;
         exp_q.push_back(e);
      end
      tick();
      start = 0; start_b = 0;
      chk("busy_after_start", b ? busy_b : busy, 1'b1);
      foreach (s[i]) begin
         for (int g = 0; g < gap[i]; g++) begin
            in_valid = 0; in_valid_b = 0;
            tick();
            chk("ready_in_gap", b ? in_ready_b : in_ready, 1'b1);
         end
         chk("valid_before_last", b ? out_valid_b : out_valid, 1'b0);
         if (b) begin in_valid_b = 1; in_data_b = 8'(s[i]); end
         else   begin in_valid   = 1; in_data   = 32'(s[i]); end
         tick();
      end
      in_valid = 0; in_valid_b = 0;
      in_data = 32'hDEAD_BEEF; in_data_b = 8'h5A;
   endtask

   // Consume the result (out_ready must already be high) and confirm IDLE.
   task automatic end_block(input bit b);
      tick();
      chk("valid_after_take", b ? out_valid_b : out_valid, 1'b0);
      chk("busy_after_take",  b ? busy_b : busy, 1'b0);
   endtask

   initial begin
      longint      sq[$];
      int          gq[$];
      longint      eq_s[$];
      int          eq_g[$];
      logic [63:0] ms;
      bit          mo;

      rst = 1;
      start = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 1;
      start_b = 0; len_b = 0; in_valid_b = 0; in_data_b = 0; out_ready_b = 1;
      repeat (2) tick();
      chk("rst_busy",  busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum",   out_sum, 0);
      chk("rst_ovf",   out_ovf, 0);
      chk("rst_count", out_count, 0);
      chk("rst_busy8", busy_b, 0);
      rst = 0;
      tick();

      // positive sum
      sq = '{1, 2, 3, 4}; gq = '{0, 0, 0, 0};
      run_block(0, 4, sq, gq);
      chk("pos_valid", out_valid, 1);
      chk("pos_ready", in_ready, 0);
      chk("pos_sum",   64'(out_sum), 64'd10);
      chk("pos_count", 64'(out_count), 64'd4);
      chk("pos_ovf",   out_ovf, 0);
      end_block(0);

      // negative sum
      sq = '{-5, 3}; gq = '{0, 0};
      run_block(0, 2, sq, gq);
      chk("neg_sum", 64'(out_sum), 64'h00FF_FFFF_FFFE);
      chk("neg_ovf", out_ovf, 0);
      end_block(0);

      // signed overflow on the 8-bit, no-guard instance
      sq = '{100, 100}; gq = '{0, 0};
      run_block(1, 2, sq, gq);
      model(sq, 8, ms, mo);
      chk("ovf8_sum",       64'(out_sum_b), 64'hC8);
      chk("ovf8_flag",      out_ovf_b, 1);
      chk("ovf8_count",     64'(out_count_b), 64'd2);
      chk("ovf8_model_sum", 64'(out_sum_b), ms);
      chk("ovf8_model_ovf", 64'(out_ovf_b), 64'(mo));
      end_block(1);
      sq = '{1, 1};
      run_block(1, 2, sq, gq);
      chk("ovf8_next_sum",  64'(out_sum_b), 64'd2);
      chk("ovf8_next_flag", out_ovf_b, 0);
      end_block(1);

      // zero length with backpressure and an ignored start
      out_ready = 0;
      run_block(0, 0, eq_s, eq_g);
      chk("zero_valid", out_valid, 1);
      chk("zero_ready", in_ready, 0);
      chk("zero_sum",   64'(out_sum), 0);
      chk("zero_count", 64'(out_count), 0);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin start = 1; len = 16'd3; end
         tick();
         start = 0;
         chk("bp_valid", out_valid, 1);
         chk("bp_ready", in_ready, 0);
         chk("bp_sum",   64'(out_sum), 0);
         chk("bp_count", 64'(out_count), 0);
      end
      out_ready = 1;
      end_block(0);
      tick();
      chk("start_ignored", busy, 0);

      // stalls between samples
      sq = '{7, 8, 9}; gq = '{0, 4, 1};
      run_block(0, 3, sq, gq);
      chk("stall_sum",   64'(out_sum), 64'd24);
      chk("stall_count", 64'(out_count), 64'd3);
      end_block(0);

      // reset in the middle of a block
      start = 1; len = 16'd5;
      tick();
      start = 0;
      in_valid = 1; in_data = 32'd1; tick();
      in_data = 32'd2; tick();
      in_valid = 0;
      #2 rst = 1;
      #1;
      chk("mid_rst_busy",  busy, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum",   64'(out_sum), 0);
      chk("mid_rst_ovf",   out_ovf, 0);
      chk("mid_rst_count", 64'(out_count), 0);
      tick();
      rst = 0;
      tick();
      sq = '{6}; gq = '{0};
      run_block(0, 1, sq, gq);
      chk("post_rst_sum",   64'(out_sum), 64'd6);
      chk("post_rst_count", 64'(out_count), 64'd1);
      end_block(0);
      chk("exp_queue_drained", 64'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
